// File: rtl/dmem_pl.sv
// Pipelined data memory with byte enables, valid/ready handshake and in-order responses.
// Optional range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_pl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_we,
    output logic                rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              vld_p   [LATENCY];
    logic              we_p    [LATENCY];
    logic              err_p   [LATENCY];
    logic [DATA_W-1:0] rdata_p [LATENCY];

    logic              advance;
    logic              accept;
    logic              misalign;
    logic              addr_err;
    logic              wr_en;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // The pipeline moves as a whole: either every stage shifts or every stage holds.
    assign advance   = rsp_ready || !rsp_valid;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    assign word_addr = req_addr >> OFF_W;
    assign idx       = word_addr[IDX_W-1:0];
    assign misalign  = |(req_addr & OFF_MASK);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_err = misalign || (word_addr >= ADDR_W'(DEPTH));
`else
    // Upper word-index bits are dropped so the index wraps modulo DEPTH.
    logic unused_word_hi;
    assign unused_word_hi = ^word_addr[ADDR_W-1:IDX_W];
    assign addr_err       = misalign;
`endif

    assign wr_en   = accept && req_we && !addr_err;
    assign rd_word = mem[idx];

    // Storage is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= merge_bytes(mem[idx], req_wdata, req_be);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i]   <= 1'b0;
                we_p[i]    <= 1'b0;
                err_p[i]   <= 1'b0;
                rdata_p[i] <= '0;
            end
        end else if (advance) begin
            // Stage 0: capture the accepted request and its array read.
            vld_p[0]   <= accept;
            we_p[0]    <= accept && req_we;
            err_p[0]   <= accept && addr_err;
            rdata_p[0] <= (accept && !req_we && !addr_err) ? rd_word : '0;
            // Stages 1..LATENCY-1: shift toward the output.
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]   <= vld_p[i-1];
                we_p[i]    <= we_p[i-1];
                err_p[i]   <= err_p[i-1];
                rdata_p[i] <= rdata_p[i-1];
            end
        end
    end

    assign rsp_valid = vld_p[LATENCY-1];
    assign rsp_we    = we_p[LATENCY-1];
    assign rsp_err   = err_p[LATENCY-1];
    assign rsp_rdata = rdata_p[LATENCY-1];

endmodule

// File: tb/tb_dmem_pl.sv
// Directed self-checking bench for dmem_pl at LATENCY 2, plus LATENCY 1 and 4 instances.
module tb_dmem_pl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;
    logic        l1_req_ready, l1_rsp_valid, l1_rsp_we, l1_rsp_err;
    logic [31:0] l1_rsp_rdata;
    logic        l4_req_ready, l4_rsp_valid, l4_rsp_we, l4_rsp_err;
    logic [31:0] l4_rsp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    dmem_pl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .rsp_err(rsp_err)
    );

    dmem_pl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l1_req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(l1_rsp_rdata),
        .rsp_we(l1_rsp_we), .rsp_err(l1_rsp_err)
    );

    dmem_pl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l4_req_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(l4_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(l4_rsp_rdata),
        .rsp_we(l4_rsp_we), .rsp_err(l4_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        cyc();

        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_we",    rsp_we,    1'b0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_l1_valid",  l1_rsp_valid, 1'b0);
        chk("rst_l4_valid",  l4_rsp_valid, 1'b0);
        rst = 1'b1;
        cyc();
        chk("post_rst_req_ready", req_ready, 1'b1);

        // Basic write then back-to-back read of 0x10
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        cyc();
        chk("basic_lat_not_yet", rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        cyc();
        chk("basic_wr_valid", rsp_valid, 1'b1);
        chk("basic_wr_we",    rsp_we,    1'b1);
        chk("basic_wr_rdata", rsp_rdata, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("basic_rd_valid", rsp_valid, 1'b1);
        chk("basic_rd_we",    rsp_we,    1'b0);
        chk("basic_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("basic_rd_err",   rsp_err,   1'b0);
        cyc();
        chk("basic_bubble", rsp_valid, 1'b0);

        // Byte enables
        drive(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
        cyc();
        drive(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        cyc();
        drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("be_rd_valid", rsp_valid, 1'b1);
        chk("be_rd_rdata", rsp_rdata, 32'h11BB33DD);
        cyc();

        // Fill words 0..5 with A0000000+i
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 4'hF, 32'(i * 4), 32'hA0000000 + 32'(i));
            cyc();
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        cyc();

        // Backpressure: six reads with a five-cycle stall
        drive(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        cyc();
        chk("bp_r0", rsp_rdata, 32'hA0000000);
        drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        cyc();
        chk("bp_r1", rsp_rdata, 32'hA0000001);
        drive(1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        rsp_ready = 1'b0;
        #1;
        chk("bp_req_ready_low", req_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_stall_valid", rsp_valid, 1'b1);
            chk("bp_stall_rdata", rsp_rdata, 32'hA0000001);
            chk("bp_stall_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        cyc();
        chk("bp_r2", rsp_rdata, 32'hA0000002);
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        cyc();
        chk("bp_r3", rsp_rdata, 32'hA0000003);
        drive(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        cyc();
        chk("bp_r4", rsp_rdata, 32'hA0000004);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("bp_r5", rsp_rdata, 32'hA0000005);
        chk("bp_r5_valid", rsp_valid, 1'b1);
        cyc();
        chk("bp_drained", rsp_valid, 1'b0);

        // Misaligned read
        drive(1'b1, 1'b0, 4'hF, 32'h13, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("mis_valid", rsp_valid, 1'b1);
        chk("mis_err",   rsp_err,   1'b1);
        chk("mis_rdata", rsp_rdata, 32'h0);

        // Out-of-range write to 0x1000, then read word 0
        drive(1'b1, 1'b1, 4'hF, 32'h1000, 32'h55AA55AA);
        cyc();
        drive(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        cyc();
        chk("oor_wr_we", rsp_we, 1'b1);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oor_wr_err", rsp_err, 1'b1);
`else
        chk("oor_wr_err", rsp_err, 1'b0);
`endif
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("oor_rd_err", rsp_err, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oor_word0", rsp_rdata, 32'hA0000000);
`else
        chk("oor_word0", rsp_rdata, 32'h55AA55AA);
`endif
        cyc();

        // Reset with three reads in flight
        drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        cyc();
        chk("rmf_before_valid", rsp_valid, 1'b1);
        chk("rmf_before_rdata", rsp_rdata, 32'hA0000001);
        drive(1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rmf_async_valid", rsp_valid, 1'b0);
        chk("rmf_async_rdata", rsp_rdata, 32'h0);
        chk("rmf_async_ready", req_ready, 1'b1);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("rmf_no_stale0", rsp_valid, 1'b0);
        cyc();
        chk("rmf_no_stale1", rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("rmf_mem_valid", rsp_valid, 1'b1);
        chk("rmf_mem_kept",  rsp_rdata, 32'hA0000002);
        repeat (5) cyc();
        chk("sweep_l1_idle", l1_rsp_valid, 1'b0);
        chk("sweep_l4_idle", l4_rsp_valid, 1'b0);

        // Latency sweep at full throughput
        drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        cyc();
        chk("l1_r0_valid", l1_rsp_valid, 1'b1);
        chk("l1_r0_rdata", l1_rsp_rdata, 32'hA0000001);
        chk("l4_c1_valid", l4_rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        cyc();
        chk("l1_r1_rdata", l1_rsp_rdata, 32'hA0000002);
        chk("l4_c2_valid", l4_rsp_valid, 1'b0);
        drive(1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        cyc();
        chk("l1_r2_rdata", l1_rsp_rdata, 32'hA0000003);
        chk("l4_c3_valid", l4_rsp_valid, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("l1_bubble",   l1_rsp_valid, 1'b0);
        chk("l4_r0_valid", l4_rsp_valid, 1'b1);
        chk("l4_r0_rdata", l4_rsp_rdata, 32'hA0000001);
        cyc();
        chk("l4_r1_valid", l4_rsp_valid, 1'b1);
        chk("l4_r1_rdata", l4_rsp_rdata, 32'hA0000002);
        cyc();
        chk("l4_r2_valid", l4_rsp_valid, 1'b1);
        chk("l4_r2_rdata", l4_rsp_rdata, 32'hA0000003);
        cyc();
        chk("l4_bubble", l4_rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
